// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// ALU codes of the M-extension, operand-forward encodings and MDU states.
package pipe_ctrl_pkg;

    localparam logic [4:0] ALU_MUL    = 5'b00010;
    localparam logic [4:0] ALU_MULH   = 5'b00011;
    localparam logic [4:0] ALU_MULHSU = 5'b00100;
    localparam logic [4:0] ALU_MULHU  = 5'b00101;
    localparam logic [4:0] ALU_DIV    = 5'b00110;
    localparam logic [4:0] ALU_DIVU   = 5'b00111;
    localparam logic [4:0] ALU_REM    = 5'b01000;
    localparam logic [4:0] ALU_REMU   = 5'b01001;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_t;

    function automatic logic is_mop(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

    function automatic logic is_div(input logic [4:0] code);
        return (code >= ALU_DIV) && (code <= ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer: IDLE/BUSY/DONE FSM with a
// latency counter; a launch in DONE chains straight into the next op.
module mdu_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic clk,
    input  logic rst_n,
    input  logic launch_i,
    input  logic is_div_i,
    output logic start_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CNT_W = 7;

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_m1;
    logic             direct_done;
    logic             start;

    assign lat_m1      = is_div_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    // Latencies of 1 or 2 leave no cycle strictly between start and done.
    assign direct_done = is_div_i ? (DIV_LAT <= 2) : (MUL_LAT <= 2);
    assign start       = launch_i && (state_q != MDU_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE, MDU_DONE: begin
                if (start) begin
                    cnt_d   = lat_m1;
                    state_d = direct_done ? MDU_DONE : MDU_BUSY;
                end else begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                // Leave BUSY when the decremented count reaches 1.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(2)) begin
                    state_d = MDU_DONE;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        start_o = start;
        busy_o  = (state_q == MDU_BUSY);
        done_o  = (state_q == MDU_DONE);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: EX/MEM operand forwarding, load-use and redirect
// hazards, and the stall interface to the multi-cycle MDU sequencer.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_alu_ctl,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            ex_reg_wr,
    input  logic            mem_reg_wr,
    input  logic            ex_mem_rd,
    input  logic            pc_sel,
    output logic            stall_pc,
    output logic            stall_id,
    output logic            flush_id,
    output logic            bubble_ex,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mdu_start,
    output logic            mdu_busy,
    output logic            mdu_done
);

    logic ex_fwd_ok;
    logic mem_fwd_ok;
    logic load_use;
    logic redirect;
    logic launch;

    // A load in EX has no result yet, so it is never a forwarding source.
    assign ex_fwd_ok  = ex_reg_wr && !ex_mem_rd && (ex_rd != '0);
    assign mem_fwd_ok = mem_reg_wr && (mem_rd != '0);

    always_comb begin
        fwd_a = FWD_RF;
        if (ex_fwd_ok && (ex_rd == id_rs1)) begin
            fwd_a = FWD_EX;
        end else if (mem_fwd_ok && (mem_rd == id_rs1)) begin
            fwd_a = FWD_MEM;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (ex_fwd_ok && (ex_rd == id_rs2)) begin
            fwd_b = FWD_EX;
        end else if (mem_fwd_ok && (mem_rd == id_rs2)) begin
            fwd_b = FWD_MEM;
        end
    end

    assign load_use = id_valid && ex_mem_rd && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    // While the MDU is busy its op is the oldest in flight, so no redirect applies.
    assign redirect = pc_sel && !mdu_busy;
    assign launch   = rst_n && id_valid && is_mop(id_alu_ctl) && !load_use && !pc_sel;

    assign stall_pc  = mdu_busy || (load_use && !redirect);
    assign stall_id  = mdu_busy || (load_use && !redirect);
    assign flush_id  = redirect;
    assign bubble_ex = redirect || load_use;

    mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .launch_i (launch),
        .is_div_i (is_div(id_alu_ctl)),
        .start_o  (mdu_start),
        .busy_o   (mdu_busy),
        .done_o   (mdu_done)
    );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: RA_W, 5, register-address width (4 selects RV32E).
REQ-002 Parameter: MUL_LAT, 3, cycles for mul/mulh/mulsu/mulu (range 1..16).
REQ-003 Parameter: DIV_LAT, 33, cycles for div/divu/rem/remu (range 1..64).
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: id_valid  in  1  instruction in ID is valid.
REQ-007 Port: id_rs1, id_rs2  in  RA_W each  ID source registers.
REQ-008 Port: id_use_rs1, id_use_rs2  in  1 each  ID reads that source.
REQ-009 Port: id_alu_ctl  in  5  ALU code of ID instruction (5'b00010..5'b01001 = M-extension).
REQ-010 Port: ex_rd, mem_rd  in  RA_W each  destination of EX / MEM instruction.
REQ-011 Port: ex_reg_wr, mem_reg_wr  in  1 each  EX / MEM writes a register.
REQ-012 Port: ex_mem_rd  in  1  EX instruction is a load.
REQ-013 Port: pc_sel  in  1  taken redirect resolved in EX.
REQ-014 Port: stall_pc, stall_id  out  1 each  hold PC / hold IF-ID register.
REQ-015 Port: flush_id, bubble_ex  out  1 each  squash IF-ID / insert NOP into ID-EX.
REQ-016 Port: fwd_a, fwd_b  out  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result.
REQ-017 Port: mdu_start, mdu_busy, mdu_done  out  1 each  MDU launch pulse / in progress / result-valid pulse.

Function
REQ-018 Forwarding combinational: fwd_a=01 if ex_reg_wr & !ex_mem_rd & ex_rd!=0 & ex_rd==id_rs1; else 10 if mem_reg_wr & mem_rd!=0 & mem_rd==id_rs1; else 00; fwd_b identical on id_rs2; EX beats MEM.
REQ-019 Load-use hazard = id_valid & ex_mem_rd & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)); asserts stall_pc, stall_id, bubble_ex for exactly that cycle.
REQ-020 pc_sel=1 asserts flush_id and bubble_ex that cycle, deasserts stall_pc/stall_id, overrides load-use hazard.
REQ-021 MDU FSM states IDLE, BUSY, DONE.
REQ-022 IDLE->BUSY when id_valid & M-op & !load-use & !pc_sel; mdu_start=1 that cycle only; counter loads MUL_LAT-1 or DIV_LAT-1 (codes 00110..01001 use DIV_LAT).
REQ-023 Launch with latency 1: IDLE->DONE directly, BUSY skipped.
REQ-024 BUSY: mdu_busy=1, stall_pc=stall_id=1, counter decrements each cycle; counter==1 -> DONE next edge.
REQ-025 DONE: one cycle, mdu_done=1, stalls released, mdu_busy=0; -> IDLE, or -> BUSY/DONE if a new eligible M-op is in ID (back-to-back allowed).
REQ-026 pc_sel ignored in BUSY (no older instruction exists); new-op launch blocked while BUSY.
REQ-027 id_valid=0: no load-use hazard, no launch; forwarding still computed.
REQ-028 Total MDU occupancy = latency cycles from mdu_start to mdu_done inclusive.

Reset
REQ-029 rst_n low: immediately FSM=IDLE, counter=0, all outputs 0 (combinational outputs reflect IDLE with inputs).
REQ-030 Reset mid-BUSY aborts operation; no mdu_done pulse follows.

Structure
REQ-031 Shared package pipe_ctrl_pkg: ALU code constants, fwd encodings (FWD_RF/FWD_EX/FWD_MEM), MDU state enum.
REQ-032 One sub-module mdu_seq: FSM plus counter, outputs mdu_start/mdu_busy/mdu_done; hazard/forwarding logic stays in pipe_ctrl.

Verification
REQ-033 ex_reg_wr=1, ex_rd=5, mem_rd=5, mem_reg_wr=1, id_rs1=5 -> fwd_a=01; ex_rd=0 instead -> fwd_a=10.
REQ-034 ex_mem_rd=1, ex_rd=7, id_rs2=7, id_use_rs2=1 -> stall_pc/stall_id/bubble_ex high one cycle; same with pc_sel=1 -> flush_id+bubble_ex, no stall.
REQ-035 div (00110), DIV_LAT=33 -> mdu_start at T, mdu_busy T+1..T+31, mdu_done T+32, stalls drop at T+32.
REQ-036 MUL_LAT=1, mul -> mdu_start and next-cycle mdu_done, no mdu_busy; two back-to-back muls -> two start/done pairs without idle gap.
REQ-037 rst_n low at BUSY cycle 10 of div -> outputs 0 asynchronously, no later mdu_done; post-reset mul launches normally.
REQ-038 M-op in ID with pc_sel=1 -> no mdu_start, flush_id=1.
